// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Latches one-cycle press pulses from a bank of debouncers as pending
//   requests. It offers them one at a time, round-robin, on a valid/ready
//   event stream. After each accepted event it waits HOLDOFF cycles before
//   offering the next one.
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   Press        one-cycle press pulses; bit i is button i
//   Event_ready  consumer accepts the offered event
//   Event_valid  an event is being offered
//   Event_id     index of the offered button; holds its last value while idle
//   Pending      latched presses that have not been accepted yet
//   Overrun      sticky; set when a press lands on a bit that is already pending
//   Busy         FSM is not in IDLE

// One pending latch per button. A press on the same edge as the clear
// re-arms the latch and is not counted as an overrun.
module button_event_arbiter_lane (
  input  logic clk,
  input  logic reset,
  input  logic press_i,
  input  logic clr_i,
  output logic pend_o,
  output logic ovr_o
);
  logic pend_q;

  always_ff @(posedge clk) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= press_i | (pend_q & ~clr_i);
  end

  assign pend_o = pend_q;
  assign ovr_o  = press_i & pend_q & ~clr_i;
endmodule

module button_event_arbiter #(
  parameter int N_BTN   = 4,
  parameter int CNT_W   = 22,
  parameter int HOLDOFF = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         Press,
  input  logic                     Event_ready,
  output logic                     Event_valid,
  output logic [$clog2(N_BTN)-1:0] Event_id,
  output logic [N_BTN-1:0]         Pending,
  output logic                     Overrun,
  output logic                     Busy
);
  localparam int ID_W = $clog2(N_BTN);
  // HOLDOFF==0 never enters the hold state, so the compare value is unused then.
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLDOFF == 0) ? '0 : CNT_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLD} state_e;

  state_e            state_q;
  logic              valid_q;
  logic [ID_W-1:0]   id_q, last_q, pick_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              overrun_q;
  logic [N_BTN-1:0]  pend, ovr_hit, clr;
  logic              accept;

  assign accept = (state_q == S_OFFER) && Event_ready;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    assign clr[i] = accept && (id_q == ID_W'(i));
    button_event_arbiter_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .press_i (Press[i]),
      .clr_i   (clr[i]),
      .pend_o  (pend[i]),
      .ovr_o   (ovr_hit[i])
    );
  end

  // Round-robin pick. Take the lowest set bit above last_q if there is one,
  // otherwise wrap around to the lowest set bit overall. Scanning downward
  // lets the lowest index win each of the two searches.
  logic [ID_W-1:0] pick_hi, pick_any;
  logic            hi_found;
  always_comb begin
    pick_hi  = '0;
    pick_any = '0;
    hi_found = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i]) pick_any = ID_W'(i);
      if (pend[i] && (i > int'(last_q))) begin
        pick_hi  = ID_W'(i);
        hi_found = 1'b1;
      end
    end
    pick_d = hi_found ? pick_hi : pick_any;
  end

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_q | (|ovr_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= ID_W'(N_BTN - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|pend) begin
            id_q    <= pick_d;
            valid_q <= 1'b1;
            state_q <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (Event_ready) begin
            valid_q <= 1'b0;
            last_q  <= id_q;
            cnt_q   <= '0;
            state_q <= (HOLDOFF == 0) ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == HOLD_LAST) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Event_valid = valid_q;
  assign Event_id    = id_q;
  assign Pending     = pend;
  assign Overrun     = overrun_q;
  assign Busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // instance A: HOLDOFF=4, instance B: HOLDOFF=0
  logic [3:0] pa, pda, pb, pdb;
  logic       ra, va, oa, ba, rb, vb, ob, bb;
  logic [1:0] ia, ib;

  button_event_arbiter #(.N_BTN(4), .CNT_W(22), .HOLDOFF(4)) dut_a (
    .clk(clk), .reset(rst), .Press(pa), .Event_ready(ra), .Event_valid(va),
    .Event_id(ia), .Pending(pda), .Overrun(oa), .Busy(ba));

  button_event_arbiter #(.N_BTN(4), .CNT_W(22), .HOLDOFF(0)) dut_b (
    .clk(clk), .reset(rst), .Press(pb), .Event_ready(rb), .Event_valid(vb),
    .Event_id(ib), .Pending(pdb), .Overrun(ob), .Busy(bb));

  int checks = 0, errors = 0, cyc = 0;
  int exp_a[$], exp_b[$], acc_a[$], acc_b[$];
  int ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitors: every accepted handshake pops one expected id.
  always @(negedge clk) begin
    if (va && ra) begin
      acc_a.push_back(cyc);
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_accept: unexpected id %0d, expected none", ia);
      end else begin
        ea = exp_a.pop_front();
        if (int'(ia) != ea) begin
          errors++;
          $display("FAIL a_accept: got id %0d, expected %0d", ia, ea);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vb && rb) begin
      acc_b.push_back(cyc);
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_accept: unexpected id %0d, expected none", ib);
      end else begin
        eb = exp_b.pop_front();
        if (int'(ib) != eb) begin
          errors++;
          $display("FAIL b_accept: got id %0d, expected %0d", ib, eb);
        end
      end
    end
  end

  task automatic do_reset();
    pa = '0; ra = 1'b0; pb = '0; rb = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    pa = '0; ra = 1'b0; pb = '0; rb = 1'b0; rst = 1'b1;

    // 1: reset state, single press, latency and hold-off
    do_reset();
    chk("rst_valid", va, 0); chk("rst_pending", pda, 0); chk("rst_overrun", oa, 0);
    chk("rst_busy", ba, 0);  chk("rst_id", ia, 0);
    exp_a.push_back(0);
    pa = 4'b0001; ra = 1'b1;
    step();
    pa = '0;
    chk("t1_pending_latched", pda, 1); chk("t1_valid_early", va, 0);
    step();
    chk("t1_valid", va, 1); chk("t1_id", ia, 0);
    step();
    chk("t1_pending_clr", pda, 0); chk("t1_valid_one_cycle", va, 0);
    chk("t1_busy", ba, 1); chk("t1_id_hold", ia, 0);
    for (int i = 0; i < 3; i++) begin step(); chk("t1_busy_hold", ba, 1); end
    step();
    chk("t1_busy_end", ba, 0);

    // 2: all four pressed, in-order service, 6-edge spacing
    do_reset();
    acc_a.delete();
    for (int i = 0; i < 4; i++) exp_a.push_back(i);
    pa = 4'b1111; ra = 1'b1;
    step();
    pa = '0;
    step(30);
    chk("t2_accepts", acc_a.size(), 4);
    if (acc_a.size() == 4)
      for (int i = 1; i < 4; i++) chk("t2_spacing", acc_a[i] - acc_a[i-1], 6);
    chk("t2_overrun", oa, 0); chk("t2_pending", pda, 0);

    // 3: stall with ready low, then a single accept
    ra = 1'b0; pa = 4'b0100;
    step();
    pa = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid_stall", va, 1); chk("t3_id_stall", ia, 2);
      step();
    end
    exp_a.push_back(2);
    ra = 1'b1;
    step();
    ra = 1'b0;
    chk("t3_pending2", int'(pda[2]), 0); chk("t3_valid_after", va, 0);
    chk("t3_id_hold", ia, 2);
    step(5);

    // 4: repeat presses on a pending bit set sticky overrun
    pa = 4'b0100; step();
    pa = '0;      step();
    pa = 4'b0100; step();
    pa = '0;
    chk("t4_overrun", oa, 1);
    pa = 4'b0100; step();
    pa = '0;      step();
    exp_a.push_back(2);
    ra = 1'b1;
    step(10);
    ra = 1'b0;
    chk("t4_overrun_sticky", oa, 1); chk("t4_pending", pda, 0);

    // 5: round-robin wrap after granting id 1
    do_reset();
    exp_a.push_back(1);
    pa = 4'b0010; ra = 1'b1;
    step();
    pa = '0;
    step(8);
    exp_a.push_back(0); exp_a.push_back(1);
    pa = 4'b0011;
    step();
    pa = '0;
    step(16);
    chk("t5_pending", pda, 0); chk("t5_drained", exp_a.size(), 0);

    // 6: reset while an offer is outstanding abandons it
    ra = 1'b0;
    pa = 4'b0001; step();
    pa = '0;      step();
    pa = 4'b0001; step();
    pa = '0;
    chk("t6_overrun_pre", oa, 1); chk("t6_valid_pre", va, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", va, 0); chk("t6_pending", pda, 0);
    chk("t6_overrun", oa, 0); chk("t6_busy", ba, 0);
    ra = 1'b1;
    step(4);
    ra = 1'b0;
    chk("t6_idle_valid", va, 0);

    // 7: HOLDOFF=0 gives 2-edge accept spacing
    acc_b.delete();
    exp_b.push_back(0); exp_b.push_back(1);
    pb = 4'b0011; rb = 1'b1;
    step();
    pb = '0;
    step(8);
    chk("t7_accepts", acc_b.size(), 2);
    if (acc_b.size() == 2) chk("t7_spacing", acc_b[1] - acc_b[0], 2);
    chk("t7_pending", pdb, 0); chk("t7_busy", bb, 0);

    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
